tag_scan_ctl: RTL and testbench
===============================

Name: tag_scan_ctl

Overview:
- Serial associative tag lookup controller built around one shared 6-bit equality comparator.
- Holds a small table of DEPTH tag/valid entries.
- On request, steps the comparator through the table one entry per cycle and reports the first matching index.
- Sits between map/cache control logic and the comparator, replacing DEPTH parallel comparators with one comparator plus sequencing.

Parameters:
- TAG_W, 6: tag width in bits; must equal the comparator width.
- DEPTH, 8: number of table entries; power of two, range 2..16.
- IDX_W, 3: index width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  lookup request; sampled only while busy=0.
- key  in  TAG_W  lookup key; captured in the cycle req is accepted.
- busy  out  1  lookup in progress; requests are ignored while high.
- done  out  1  one-cycle pulse when the lookup result is valid.
- hit  out  1  result: a match was found.
- hit_idx  out  IDX_W  result: lowest matching index; 0 on miss.
- wr_en  in  1  write a table entry.
- wr_idx  in  IDX_W  entry to write.
- wr_tag  in  TAG_W  tag value to write.
- wr_valid  in  1  valid bit to write.
- inval_all  in  1  clear all valid bits.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0, done=0, hit=0, hit_idx=0.
  - All valid bits cleared; tag contents don't-care.
  - A reset mid-scan abandons the lookup with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If req=1: latch key into key_q, set scan index idx=0, set busy=1, go to SCAN.
  - hit and hit_idx keep the previous result until the new lookup completes.
- SCAN:
  - Comparator enable = valid[idx]; inputs key_q and tag[idx].
  - If eq=1: next hit=1, hit_idx=idx, go to DONE.
  - Else if idx==DEPTH-1: next hit=0, hit_idx=0, go to DONE.
  - Else idx<=idx+1.
  - idx is IDX_W bits and never wraps; the terminal test stops it at DEPTH-1.
- DONE: done=1 for exactly this cycle; busy=0; next state IDLE.
  - A req present in the DONE cycle is ignored; a new req is accepted from the following IDLE cycle.
- Latency, with req accepted in cycle c:
  - Hit at index i: done high in cycle c+i+2.
  - Miss: done high in cycle c+DEPTH+1.
- Priority: the lowest matching index always wins; duplicate tags are legal.
- Writes:
  - Accepted in any state; take effect at the next edge.
  - A compare in the same cycle sees the old entry value.
  - A write to an entry not yet scanned is visible when the scan reaches it.
- inval_all:
  - Clears all valid bits at the next edge.
  - If asserted during SCAN, the scan terminates next edge with hit=0 and goes to DONE, even if eq=1 that cycle.
- wr_en together with inval_all: the tag is written, but the valid bit ends 0 (inval wins).
- key changes after acceptance have no effect; key_q is held.
- Outputs are registered; done/hit/hit_idx never glitch combinationally.

Decomposition:
- Shared package: TAG_W and DEPTH defaults; state encoding constants ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2.
- One sub-module, tag_cmp: enable-gated TAG_W equality. Output eq = enb & (a==b). Purely combinational; one instance in tag_scan_ctl.
- Tag/valid storage and the FSM live in tag_scan_ctl.

Test Plan:
- Reset, then write tags 0x05@0, 0x2A@3, 0x2A@6 (all valid); req with key=0x2A -> done in cycle c+5, hit=1, hit_idx=3; busy high cycles c+1..c+4.
- Same table, req key=0x3F -> done in cycle c+9 (DEPTH=8), hit=0, hit_idx=0.
- Write 0x11@2 with wr_valid=0; req key=0x11 -> miss. Then rewrite with wr_valid=1; req again -> hit, hit_idx=2, done at c+4.
- Start lookup key=0x2A; assert inval_all in the cycle idx=1 -> done the next cycle with hit=0. Subsequent lookup of 0x2A misses.
- Pulse req during SCAN and during DONE -> ignored: exactly one done pulse, and key_q is unchanged.
- Drop reset_n mid-SCAN -> busy=0, done=0, hit=0 immediately. After release, lookup of a previously valid tag misses.

Source files
------------

// File: rtl/tag_scan_ctl_pkg.sv
// Shared constants for the serial tag lookup controller.
// Provides default tag/table geometry and the FSM state encoding.
package tag_scan_ctl_pkg;

    localparam int unsigned TAG_W_DEF = 6;
    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned IDX_W_DEF = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tag_scan_ctl_if.sv
// Lookup and table-write bus between map/cache control and tag_scan_ctl.
//   master: requester side (drives req/key and table writes, sees results)
//   slave : controller side
interface tag_scan_ctl_if
    import tag_scan_ctl_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
);
    logic             req;
    logic [TAG_W-1:0] key;
    logic             busy;
    logic             done;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_valid;
    logic             inval_all;

    modport master (
        output req, key, wr_en, wr_idx, wr_tag, wr_valid, inval_all,
        input  busy, done, hit, hit_idx
    );

    modport slave (
        input  req, key, wr_en, wr_idx, wr_tag, wr_valid, inval_all,
        output busy, done, hit, hit_idx
    );
endinterface

// File: rtl/tag_cmp.sv
// Enable-gated equality comparator shared by the whole tag table.
//   enb : compare enable (entry valid)
//   a,b : operands
//   eq  : enb & (a == b), combinational
module tag_cmp #(
    parameter int unsigned W = 6
) (
    input  logic         enb,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);
    assign eq = enb & (a == b);
endmodule

// File: rtl/tag_scan_ctl.sv
// Serial associative tag lookup: one comparator stepped over DEPTH entries,
// reporting the lowest matching index.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : req/key lookup, busy/done/hit/hit_idx result,
//                  wr_* entry write, inval_all valid clear
module tag_scan_ctl
    import tag_scan_ctl_pkg::*;
#(
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset_n,
    tag_scan_ctl_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TAG_W-1:0] key_q, key_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;

    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic             eq;

    // Single shared comparator, pointed at the current scan entry
    tag_cmp #(.W(TAG_W)) u_cmp (
        .enb (valid_q[idx_q]),
        .a   (key_q),
        .b   (tag_q[idx_q]),
        .eq  (eq)
    );

    // Tag storage needs no reset; only valid bits define table contents
    always_ff @(posedge clk) begin
        if (bus.wr_en) tag_q[bus.wr_idx] <= bus.wr_tag;
    end

    // Valid bits; a bulk invalidate overrides a same-cycle write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (bus.inval_all) begin
            valid_q <= '0;
        end else if (bus.wr_en) begin
            valid_q[bus.wr_idx] <= bus.wr_valid;
        end
    end

    // FSM and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    // Next-state and next-output logic; results change only on scan exit
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        key_d     = key_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    key_d   = bus.key;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bus.inval_all) begin
                    // Table is being wiped: abort as a miss even on a match
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (eq) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (idx_q == LAST_IDX) begin
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hit     = hit_q;
    assign bus.hit_idx = hit_idx_q;

endmodule

// File: tb/tb_tag_scan_ctl.sv
// Self-checking bench for tag_scan_ctl: directed scenarios plus randomized
// lookups compared against a first-match table model.
module tb_tag_scan_ctl;

    localparam int TAG_W = 6;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int MAX_WAIT = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    logic [TAG_W-1:0] m_tag [DEPTH];
    logic             m_valid [DEPTH];

    tag_scan_ctl_if #(.TAG_W(TAG_W), .IDX_W(IDX_W)) bus ();

    tag_scan_ctl #(.TAG_W(TAG_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: lowest valid matching entry; latency counted from accept cycle
    function automatic void ref_lookup(input logic [TAG_W-1:0] k, output logic h,
                                       output logic [IDX_W-1:0] i, output int lat);
        h = 1'b0;
        i = '0;
        lat = DEPTH + 1;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (m_valid[j] && m_tag[j] == k) begin
                h = 1'b1;
                i = IDX_W'(j);
                lat = j + 2;
            end
        end
    endfunction

    task automatic wr(input int idx, input logic [TAG_W-1:0] t, input logic v);
        bus.wr_en = 1'b1;
        bus.wr_idx = IDX_W'(idx);
        bus.wr_tag = t;
        bus.wr_valid = v;
        tick();
        bus.wr_en = 1'b0;
        m_tag[idx] = t;
        m_valid[idx] = v;
    endtask

    // Issue one lookup and report what the DUT showed; no judging here
    task automatic do_lookup(input logic [TAG_W-1:0] k, output logic o_hit,
                             output logic [IDX_W-1:0] o_idx, output int o_lat,
                             output int o_busy_err, output int o_extra_done);
        bus.req = 1'b1;
        bus.key = k;
        tick();
        bus.req = 1'b0;
        bus.key = ~k;
        o_lat = 1;
        o_busy_err = 0;
        while (!bus.done && o_lat < MAX_WAIT) begin
            if (bus.busy !== 1'b1) o_busy_err++;
            tick();
            o_lat++;
        end
        o_hit = bus.hit;
        o_idx = bus.hit_idx;
        if (bus.busy !== 1'b0) o_busy_err++;
        tick();
        o_extra_done = (bus.done !== 1'b0) ? 1 : 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.busy, bus.done, bus.hit, bus.hit_idx} !== 6'b0)
            $display("FAIL reset_outputs: got %b want 000000",
                     {bus.busy, bus.done, bus.hit, bus.hit_idx});
        else n_pass++;
        reset_n = 1'b1;
        for (int j = 0; j < DEPTH; j++) m_valid[j] = 1'b0;
        tick();
    endtask

    task automatic test_hit();
        logic h; logic [IDX_W-1:0] i; int lat, be, xd;
        wr(0, 6'h05, 1'b1);
        wr(3, 6'h2A, 1'b1);
        wr(6, 6'h2A, 1'b1);
        do_lookup(6'h2A, h, i, lat, be, xd);
        n_checks++;
        if (lat != 5) $display("FAIL hit_latency: got %0d want 5", lat); else n_pass++;
        n_checks++;
        if (h !== 1'b1 || i !== 3'd3) $display("FAIL hit_result: got hit=%b idx=%0d want hit=1 idx=3", h, i); else n_pass++;
        n_checks++;
        if (be != 0 || xd != 0) $display("FAIL hit_busy_done: got busy_err=%0d extra_done=%0d want 0/0", be, xd); else n_pass++;
    endtask

    task automatic test_miss();
        logic h; logic [IDX_W-1:0] i; int lat, be, xd;
        do_lookup(6'h3F, h, i, lat, be, xd);
        n_checks++;
        if (lat != DEPTH + 1) $display("FAIL miss_latency: got %0d want %0d", lat, DEPTH + 1); else n_pass++;
        n_checks++;
        if (h !== 1'b0 || i !== 3'd0) $display("FAIL miss_result: got hit=%b idx=%0d want hit=0 idx=0", h, i); else n_pass++;
        n_checks++;
        if (be != 0 || xd != 0) $display("FAIL miss_busy_done: got busy_err=%0d extra_done=%0d want 0/0", be, xd); else n_pass++;
    endtask

    task automatic test_valid_bit();
        logic h; logic [IDX_W-1:0] i; int lat, be, xd;
        wr(2, 6'h11, 1'b0);
        do_lookup(6'h11, h, i, lat, be, xd);
        n_checks++;
        if (h !== 1'b0 || lat != DEPTH + 1) $display("FAIL invalid_entry: got hit=%b lat=%0d want hit=0 lat=%0d", h, lat, DEPTH + 1); else n_pass++;
        wr(2, 6'h11, 1'b1);
        do_lookup(6'h11, h, i, lat, be, xd);
        n_checks++;
        if (h !== 1'b1 || i !== 3'd2 || lat != 4) $display("FAIL valid_entry: got hit=%b idx=%0d lat=%0d want hit=1 idx=2 lat=4", h, i, lat); else n_pass++;
    endtask

    task automatic test_inval_scan();
        logic h; logic [IDX_W-1:0] i; int lat, be, xd;
        bus.req = 1'b1;
        bus.key = 6'h2A;
        tick();                     // c+1, idx=0
        bus.req = 1'b0;
        tick();                     // c+2, idx=1
        bus.inval_all = 1'b1;
        bus.wr_en = 1'b1;           // concurrent write: tag lands, valid must not
        bus.wr_idx = 3'd7;
        bus.wr_tag = 6'h2A;
        bus.wr_valid = 1'b1;
        tick();                     // c+3
        bus.inval_all = 1'b0;
        bus.wr_en = 1'b0;
        for (int j = 0; j < DEPTH; j++) m_valid[j] = 1'b0;
        m_tag[7] = 6'h2A;
        n_checks++;
        if (bus.done !== 1'b1 || bus.hit !== 1'b0 || bus.hit_idx !== 3'd0 || bus.busy !== 1'b0)
            $display("FAIL inval_abort: got done=%b hit=%b idx=%0d busy=%b want 1/0/0/0",
                     bus.done, bus.hit, bus.hit_idx, bus.busy);
        else n_pass++;
        tick();
        do_lookup(6'h2A, h, i, lat, be, xd);
        n_checks++;
        if (h !== 1'b0 || lat != DEPTH + 1) $display("FAIL after_inval: got hit=%b lat=%0d want hit=0 lat=%0d", h, lat, DEPTH + 1); else n_pass++;
    endtask

    task automatic test_req_ignored();
        int lat, pulses;
        wr(0, 6'h05, 1'b1);
        wr(3, 6'h2A, 1'b1);
        bus.req = 1'b1;
        bus.key = 6'h2A;
        tick();                     // c+1: stray req with a key that would hit at 0
        bus.key = 6'h05;
        tick();
        bus.req = 1'b0;
        lat = 2;
        while (!bus.done && lat < MAX_WAIT) begin tick(); lat++; end
        n_checks++;
        if (lat != 5 || bus.hit !== 1'b1 || bus.hit_idx !== 3'd3)
            $display("FAIL req_in_scan: got lat=%0d hit=%b idx=%0d want lat=5 hit=1 idx=3", lat, bus.hit, bus.hit_idx);
        else n_pass++;
        bus.req = 1'b1;             // req in the DONE cycle
        bus.key = 6'h05;
        tick();
        bus.req = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL req_in_done_busy: got %b want 0", bus.busy); else n_pass++;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        n_checks++;
        if (pulses != 0) $display("FAIL req_in_done_pulses: got %0d want 0", pulses); else n_pass++;
    endtask

    task automatic test_write_during_scan();
        int lat;
        bus.req = 1'b1;
        bus.key = 6'h33;
        tick();                     // c+1: idx 0 compares the old entry 0
        bus.req = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_idx = 3'd0;
        bus.wr_tag = 6'h33;
        bus.wr_valid = 1'b1;
        tick();                     // c+2: entry 5 not yet scanned
        bus.wr_idx = 3'd5;
        tick();
        bus.wr_en = 1'b0;
        m_tag[0] = 6'h33; m_valid[0] = 1'b1;
        m_tag[5] = 6'h33; m_valid[5] = 1'b1;
        lat = 3;
        while (!bus.done && lat < MAX_WAIT) begin tick(); lat++; end
        n_checks++;
        if (lat != 7 || bus.hit !== 1'b1 || bus.hit_idx !== 3'd5)
            $display("FAIL write_in_scan: got lat=%0d hit=%b idx=%0d want lat=7 hit=1 idx=5", lat, bus.hit, bus.hit_idx);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        logic h; logic [IDX_W-1:0] i; int lat, be, xd;
        bus.req = 1'b1;
        bus.key = 6'h2A;
        tick();
        bus.req = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.hit, bus.hit_idx} !== 6'b0)
            $display("FAIL reset_mid_scan: got %b want 000000", {bus.busy, bus.done, bus.hit, bus.hit_idx});
        else n_pass++;
        tick();
        reset_n = 1'b1;
        for (int j = 0; j < DEPTH; j++) m_valid[j] = 1'b0;
        tick();
        do_lookup(6'h2A, h, i, lat, be, xd);
        n_checks++;
        if (h !== 1'b0 || lat != DEPTH + 1) $display("FAIL after_reset: got hit=%b lat=%0d want hit=0 lat=%0d", h, lat, DEPTH + 1); else n_pass++;
    endtask

    task automatic test_random();
        logic h, eh; logic [IDX_W-1:0] i, ei; int lat, elat, be, xd;
        logic [TAG_W-1:0] k;
        for (int n = 0; n < 24; n++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                wr(int'($urandom_range(0, DEPTH - 1)), TAG_W'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)));
            k = TAG_W'($urandom_range(0, 7));
            ref_lookup(k, eh, ei, elat);
            do_lookup(k, h, i, lat, be, xd);
            n_checks++;
            if (h !== eh || i !== ei || lat != elat || be != 0 || xd != 0)
                $display("FAIL random_%0d key=%0h: got hit=%b idx=%0d lat=%0d be=%0d xd=%0d want hit=%b idx=%0d lat=%0d be=0 xd=0",
                         n, k, h, i, lat, be, xd, eh, ei, elat);
            else n_pass++;
        end
    endtask

    initial begin
        bus.req = 1'b0;
        bus.key = '0;
        bus.wr_en = 1'b0;
        bus.wr_idx = '0;
        bus.wr_tag = '0;
        bus.wr_valid = 1'b0;
        bus.inval_all = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            m_tag[j] = '0;
            m_valid[j] = 1'b0;
        end
        test_reset();
        test_hit();
        test_miss();
        test_valid_bit();
        test_inval_scan();
        test_req_ignored();
        test_write_during_scan();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
